uart_bus_responder: RTL and testbench



---
 rtl/uart_bus_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_bus_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_responder.sv
// UART peripheral answering the CPU rdn/wrn/data_ready/tbre/tsre handshake.
// Serializes written bytes as 8N1 on txd and deserializes 8N1 frames from rxd.
module uart_bus_responder #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rdn,
    input  logic       wrn,
    input  logic [7:0] bus_din,
    output logic [7:0] bus_dout,
    output logic       bus_doe,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    output logic       txd,
    input  logic       rxd,
    output logic       rx_overrun,
    output logic       rx_frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    logic          rdn_q, rdn_prev_q, wrn_q, wrn_prev_q;
    logic          rx_s1_q, rx_s2_q;
    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tsr_q, tsr_d, thr_q, thr_d;
    logic          tbre_q, tbre_d, tsre_q, tsre_d;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rsr_q, rsr_d, rbr_q, rbr_d;
    logic          dr_q, dr_d, ovr_q, ovr_d, fe_q, fe_d;
    logic          rd_rise, wr_rise;

    assign rd_rise = rdn_q & ~rdn_prev_q;
    assign wr_rise = wrn_q & ~wrn_prev_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rdn_q      <= 1'b1;
            rdn_prev_q <= 1'b1;
            wrn_q      <= 1'b1;
            wrn_prev_q <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tsr_q      <= '0;
            thr_q      <= '0;
            tbre_q     <= 1'b1;
            tsre_q     <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rsr_q      <= '0;
            rbr_q      <= '0;
            dr_q       <= 1'b0;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            rdn_q      <= rdn;
            rdn_prev_q <= rdn_q;
            wrn_q      <= wrn;
            wrn_prev_q <= wrn_q;
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tsr_q      <= tsr_d;
            thr_q      <= thr_d;
            tbre_q     <= tbre_d;
            tsre_q     <= tsre_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rsr_q      <= rsr_d;
            rbr_q      <= rbr_d;
            dr_q       <= dr_d;
            ovr_q      <= ovr_d;
            fe_q       <= fe_d;
        end
    end

    // Write acceptance and TX load are mutually exclusive: one needs tbre=1, the other tbre=0.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tsr_d      = tsr_q;
        thr_d      = thr_q;
        tbre_d     = tbre_q;
        tsre_d     = tsre_q;
        if (wr_rise && tbre_q) begin
            thr_d  = bus_din;
            tbre_d = 1'b0;
        end
        case (tx_state_q)
            TX_IDLE: begin
                if (!tbre_q) begin
                    tsr_d      = thr_q;
                    tbre_d     = 1'b1;
                    tsre_d     = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    tsr_d    = {1'b0, tsr_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    if (!tbre_q) begin
                        tsr_d      = thr_q;
                        tbre_d     = 1'b1;
                        tx_state_d = TX_START;
                    end else begin
                        tsre_d     = 1'b1;
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        case (tx_state_q)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = tsr_q[0];
            default:  txd = 1'b1;
        endcase
    end

    // A stop-bit sample coinciding with a read-release lets the new byte win.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rsr_d      = rsr_q;
        rbr_d      = rbr_q;
        dr_d       = dr_q;
        ovr_d      = ovr_q;
        fe_d       = fe_q;
        if (rd_rise) begin
            dr_d  = 1'b0;
            ovr_d = 1'b0;
        end
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_s2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d = '0;
                    rsr_d    = {rx_s2_q, rsr_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (!rx_s2_q) begin
                        fe_d = 1'b1;
                    end else if (!dr_q || rd_rise) begin
                        rbr_d = rsr_q;
                        dr_d  = 1'b1;
                        fe_d  = 1'b0;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign bus_doe      = ~rdn_q;
    assign bus_dout     = rdn_q ? 8'h00 : rbr_q;
    assign data_ready   = dr_q;
    assign tbre         = tbre_q;
    assign tsre         = tsre_q;
    assign rx_overrun   = ovr_q;
    assign rx_frame_err = fe_q;
endmodule

// File: tb/tb_uart_bus_responder.sv
// Scoreboard bench for uart_bus_responder: a txd frame decoder and a bus-read
// monitor pop expected bytes queued by the directed stimulus.
module tb_uart_bus_responder;
    localparam int CPB = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       rdn = 1'b1;
    logic       wrn = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] bus_din = 8'h00;
    logic [7:0] bus_dout;
    logic       bus_doe, data_ready, tbre, tsre, txd, rx_overrun, rx_frame_err;

    uart_bus_responder #(.CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RST(RST), .rdn(rdn), .wrn(wrn), .bus_din(bus_din),
        .bus_dout(bus_dout), .bus_doe(bus_doe), .data_ready(data_ready),
        .tbre(tbre), .tsre(tsre), .txd(txd), .rxd(rxd),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rd[$];
    int tx_starts[$];
    int dr_lat = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic wait_flag(input string nm, input int which, input logic val, input int maxc);
        logic s;
        bit   hit;
        hit = 1'b0;
        for (int i = 0; i < maxc && !hit; i++) begin
            @(negedge CLK);
            s = (which == 0) ? tbre : tsre;
            if (s == val) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, got %0b, expected %0b", nm, maxc, s, val);
        end
    endtask

    task automatic cpu_write(input logic [7:0] b);
        @(negedge CLK);
        bus_din = b;
        wrn = 1'b0;
        @(negedge CLK);
        wrn = 1'b1;
    endtask

    task automatic cpu_read();
        @(negedge CLK);
        rdn = 1'b0;
        repeat (3) @(negedge CLK);
        rdn = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        int st;
        @(negedge CLK);
        st = cyc;
        for (int i = 0; i < 10; i++) begin
            rxd = (i == 0) ? 1'b0 : (i == 9) ? stopb : b[i-1];
            repeat (CPB) begin
                @(negedge CLK);
                if (dr_lat < 0 && data_ready) dr_lat = cyc - st;
            end
        end
        rxd = 1'b1;
    endtask

    // txd decoder: samples each bit at its centre, abandons frames cut by reset.
    initial begin
        logic [7:0] b;
        logic       ab, ok_start, ok_stop;
        int         st;
        forever begin
            @(negedge CLK);
            if (RST && txd === 1'b0) begin
                st = cyc; ab = 1'b0; b = 8'h00; ok_start = 1'b0; ok_stop = 1'b0;
                for (int i = 1; i <= 152; i++) begin
                    @(negedge CLK);
                    if (!RST) ab = 1'b1;
                    if (i == 8) ok_start = (txd == 1'b0);
                    else if (i > 8 && i <= 136 && ((i - 8) % 16) == 0) b = {txd, b[7:1]};
                    else if (i == 152) ok_stop = (txd == 1'b1);
                end
                if (!ab) begin
                    tx_starts.push_back(st);
                    if (exp_tx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got frame %0h, expected no frame", b);
                    end else begin
                        chk("tx_byte", b, exp_tx.pop_front());
                        chk("tx_start_bit", ok_start, 1);
                        chk("tx_stop_bit", ok_stop, 1);
                    end
                end
            end
        end
    end

    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (bus_doe && !prev) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got read %0h, expected no read", bus_dout);
                end else begin
                    chk("rd_byte", bus_dout, exp_rd.pop_front());
                end
            end
            prev = bus_doe;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int tbre_lo, tsre_lo;
        #1 RST = 1'b0;
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_tbre", tbre, 1);
        chk("rst_tsre", tsre, 1);
        chk("rst_data_ready", data_ready, 0);
        chk("rst_bus_doe", bus_doe, 0);
        chk("rst_bus_dout", bus_dout, 8'h00);
        chk("rst_overrun", rx_overrun, 0);
        chk("rst_frame_err", rx_frame_err, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // single frame: tbre low one cycle, tsre low for the full 160-cycle frame
        exp_tx.push_back(8'hA5);
        cpu_write(8'hA5);
        tbre_lo = 0; tsre_lo = 0;
        repeat (200) begin
            @(negedge CLK);
            if (!tbre) tbre_lo++;
            if (!tsre) tsre_lo++;
        end
        chk("t1_tbre_low_cycles", tbre_lo, 1);
        chk("t1_tsre_low_cycles", tsre_lo, 160);
        repeat (10) @(negedge CLK);

        // back-to-back frames, third write dropped while tbre=0
        exp_tx.push_back(8'h11);
        cpu_write(8'h11);
        wait_flag("t2_tbre_back", 0, 1'b1, 10);
        exp_tx.push_back(8'h22);
        cpu_write(8'h22);
        wait_flag("t2_tbre_full", 0, 1'b0, 10);
        cpu_write(8'h33);
        wait_flag("t2_tsre_idle", 1, 1'b1, 500);
        repeat (200) @(negedge CLK);
        chk("t2_frame_count", tx_starts.size(), 3);
        if (tx_starts.size() >= 3) chk("t2_no_gap", tx_starts[2] - tx_starts[1], 160);

        // receive 0x3C and read it back
        dr_lat = -1;
        send_rx(8'h3C, 1'b1);
        chk("t3_latency_ok", (dr_lat >= 145 && dr_lat <= 160), 1);
        chk("t3_data_ready", data_ready, 1);
        exp_rd.push_back(8'h3C);
        @(negedge CLK);
        rdn = 1'b0;
        @(negedge CLK);
        chk("t3_bus_doe_on", bus_doe, 1);
        chk("t3_bus_dout", bus_dout, 8'h3C);
        rdn = 1'b1;
        repeat (2) @(negedge CLK);
        chk("t3_dr_cleared", data_ready, 0);
        chk("t3_bus_doe_off", bus_doe, 0);

        // overrun: the first byte is kept
        send_rx(8'h01, 1'b1);
        send_rx(8'h02, 1'b1);
        repeat (5) @(negedge CLK);
        chk("t4_data_ready", data_ready, 1);
        chk("t4_overrun", rx_overrun, 1);
        exp_rd.push_back(8'h01);
        cpu_read();
        repeat (3) @(negedge CLK);
        chk("t4_overrun_clr", rx_overrun, 0);
        chk("t4_dr_clr", data_ready, 0);

        // start glitch, then a framing error, then a good frame clears it
        @(negedge CLK);
        rxd = 1'b0;
        repeat (4) @(negedge CLK);
        rxd = 1'b1;
        repeat (40) @(negedge CLK);
        chk("t5_glitch_dr", data_ready, 0);
        chk("t5_glitch_fe", rx_frame_err, 0);
        chk("t5_glitch_ovr", rx_overrun, 0);
        send_rx(8'h55, 1'b0);
        repeat (30) @(negedge CLK);
        chk("t5_frame_err", rx_frame_err, 1);
        chk("t5_fe_dr", data_ready, 0);
        send_rx(8'h7E, 1'b1);
        repeat (5) @(negedge CLK);
        chk("t5_fe_clr", rx_frame_err, 0);
        chk("t5_good_dr", data_ready, 1);
        exp_rd.push_back(8'h7E);
        cpu_read();
        repeat (5) @(negedge CLK);

        // asynchronous reset in the middle of a data bit
        cpu_write(8'hC3);
        repeat (60) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("t6_txd", txd, 1);
        chk("t6_tbre", tbre, 1);
        chk("t6_tsre", tsre, 1);
        @(negedge CLK);
        RST = 1'b1;
        repeat (200) @(negedge CLK);
        exp_tx.push_back(8'h5A);
        cpu_write(8'h5A);
        wait_flag("t6_tsre_busy", 1, 1'b0, 10);
        wait_flag("t6_tsre_idle", 1, 1'b1, 400);
        repeat (20) @(negedge CLK);

        chk("tx_queue_empty", exp_tx.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
